// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: JTAG TAP reset/IR/DR/idle sequencer; define JTAG_SCAN_TRST_EN to add active-low jtag_trst
module jtag_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [6:0]         req_len,
  input  logic [MAX_LEN-1:0] req_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
`ifdef JTAG_SCAN_TRST_EN
  output logic               jtag_trst,
`endif
  input  logic               jtag_tdo
);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [1:0] OP_RST = 2'b00, OP_IR = 2'b01, OP_WAIT = 2'b11;
  typedef enum logic [2:0] {IDLE, HEADER, SHIFT, TRAILER, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op;
  logic [MAX_LEN-1:0] data;
  logic [6:0] n, idx, lim, hdr_len, eff_len;
  logic [5:0] hdr_pat;
  logic [8:0] div_cnt;
  logic tms_q, active, accept, pend, rise, last, scan;
  assign accept = req_valid && req_ready;
  assign active = state == HEADER || state == SHIFT || state == TRAILER;
  assign scan = op == OP_IR || op == 2'b10;
  assign pend = div_cnt == 9'(2 * CLK_DIV - 1);
  assign rise = div_cnt == 9'(CLK_DIV);
  assign lim = state == HEADER ? hdr_len : state == SHIFT ? n : 7'd2;
  assign last = idx == lim - 7'd1;
  assign eff_len = req_len == 7'd0 ? 7'd1 : req_len > 7'(MAX_LEN) ? 7'(MAX_LEN) : req_len;
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign rsp_valid = state == DONE;
  assign jtag_tck = active && div_cnt >= 9'(CLK_DIV);
  assign jtag_tms = state == HEADER ? hdr_pat[idx[2:0]] :
                    state == SHIFT ? scan && last :
                    state == TRAILER ? idx == 7'd0 : tms_q;
  assign jtag_tdi = state == SHIFT && scan && data[idx[IW-1:0]];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = req_op == OP_WAIT ? (req_len == 7'd0 ? DONE : SHIFT) : HEADER;
      HEADER:  if (pend && last) state_n = op == OP_RST ? DONE : SHIFT;
      SHIFT:   if (pend && last) state_n = scan ? TRAILER : DONE;
      TRAILER: if (pend && last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      tms_q <= 1'b1;
      rsp_data <= '0;
      div_cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if (active) tms_q <= jtag_tms;
      if (accept) begin
        op <= req_op;
        data <= req_data;
        n <= req_op == OP_WAIT ? req_len : eff_len;
        hdr_pat <= req_op == OP_RST ? 6'b011111 : req_op == OP_IR ? 6'b000011 : 6'b000001;
        hdr_len <= req_op == OP_RST ? 7'd6 : req_op == OP_IR ? 7'd4 : 7'd3;
        rsp_data <= '0;
        div_cnt <= '0;
        idx <= '0;
      end else if (active) begin
        div_cnt <= pend ? 9'd0 : div_cnt + 9'd1;
        if (pend) idx <= last ? 7'd0 : idx + 7'd1;
        if (state == SHIFT && scan && rise) rsp_data[idx[IW-1:0]] <= jtag_tdo;
      end
    end
  end
`ifdef JTAG_SCAN_TRST_EN
  logic trst_q;
  always_ff @(posedge clk_in) trst_q <= !reset;
  assign jtag_trst = trst_q && !(state == HEADER && op == OP_RST && idx < 7'd5);
`endif
endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// tb_jtag_scan_ctrl: directed scoreboard bench driving jtag_scan_ctrl against a behavioural TAP
module tb_jtag_scan_ctrl;
  localparam int D = 2;
  localparam logic [1:0] RST = 2'b00, IR = 2'b01, DR = 2'b10, WT = 2'b11;
  typedef struct {logic [63:0] d; int per;} exp_t;
  typedef enum int {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR, SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  logic clk_in = 0, reset = 1, req_valid = 0, jtag_tdo = 0;
  logic [1:0] req_op = 0;
  logic [6:0] req_len = 0;
  logic [63:0] req_data = 0, rsp_data, dv;
  logic req_ready, rsp_valid, busy, jtag_tck, jtag_tms, jtag_tdi, prev_tms, prev_tdi;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, rsp_cyc = 0, acc_cnt = 0, rsp_cnt = 0, low_cnt = 0;
  exp_t sb[$];
  exp_t e;
  logic tms_log[$];
  tap_t tap = TLR;
  logic [31:0] dr = 0;
  int dl = 1;
  logic [4:0] ir = 5'h01, irs = 0;
  jtag_scan_ctrl #(.CLK_DIV(D), .MAX_LEN(64)) dut (
    .clk_in(clk_in), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_len(req_len), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:  return m ? TLR : RTI;
      RTI:  return m ? SDS : RTI;
      SDS:  return m ? SIS : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR : SHDR;
      UDR:  return m ? SDS : RTI;
      SIS:  return m ? TLR : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR : SHIR;
      default: return m ? SDS : RTI;
    endcase
  endfunction
  always @(posedge jtag_tck) begin
    tms_log.push_back(jtag_tms);
    case (tap)
      CDR: begin dr = ir == 5'h01 ? 32'hDEADBEEF : 32'h0; dl = ir == 5'h01 ? 32 : 1; end
      SHDR: dr = (dr >> 1) | (32'(jtag_tdi) << (dl - 1));
      CIR: irs = 5'h01;
      SHIR: irs = {jtag_tdi, irs[4:1]};
      UIR: ir = irs;
      default: ;
    endcase
    tap = tap_next(tap, jtag_tms);
    if (tap == TLR) ir = 5'h01;
  end
  always @(negedge jtag_tck) jtag_tdo = tap == SHDR ? dr[0] : tap == SHIR ? irs[0] : 1'b0;
  always @(negedge clk_in) if (!reset) begin
    if (jtag_tck) chk("tms_tdi_hold", {62'd0, jtag_tms, jtag_tdi}, {62'd0, prev_tms, prev_tdi});
    prev_tms = jtag_tms;
    prev_tdi = jtag_tdi;
    if (!busy) low_cnt++;
    if (req_valid && req_ready) begin acc_cyc = cyc; acc_cnt++; end
    if (rsp_valid) begin
      rsp_cyc = cyc;
      rsp_cnt++;
      chk("sb_pending", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("latency", 64'(rsp_cyc - acc_cyc), 64'(2 * D * e.per + 1));
      end
    end
  end
  task automatic issue(input logic [1:0] op, input logic [6:0] len, input logic [63:0] d);
    int t = 0;
    @(posedge clk_in); #1;
    req_op = op; req_len = len; req_data = d; req_valid = 1;
    tms_log.delete();
    while (!req_ready && t < 1000) begin @(posedge clk_in); #1; t++; end
    chk("req_ready", 64'(req_ready), 1);
    @(posedge clk_in); #1;
    req_valid = 0;
  endtask
  task automatic wait_rsp();
    int n0 = rsp_cnt;
    int t = 0;
    while (rsp_cnt == n0 && t < 2000) begin @(posedge clk_in); #1; t++; end
    chk("rsp_seen", 64'(rsp_cnt - n0), 1);
  endtask
  task automatic run(input logic [1:0] op, input logic [6:0] len, input logic [63:0] d, input logic [63:0] exp, input int per);
    sb.push_back('{exp, per});
    issue(op, len, d);
    wait_rsp();
    chk("tck_periods", 64'(tms_log.size()), 64'(per));
  endtask
  initial begin
    logic [5:0] tv;
    int n0, t;
    repeat (3) @(posedge clk_in); #1;
    chk("rst_ready", 64'(req_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_tck", 64'(jtag_tck), 0);
    chk("rst_tms", 64'(jtag_tms), 1);
    chk("rst_tdi", 64'(jtag_tdi), 0);
    reset = 0;
    run(RST, 7'd9, 64'h0, 64'h0, 6);
    tv = '0;
    for (int i = 0; i < 6 && i < tms_log.size(); i++) tv[i] = tms_log[i];
    chk("tap_reset_tms", 64'(tv), 64'(6'b011111));
    run(IR, 7'd5, 64'h01, 64'h01, 11);
    run(DR, 7'd32, 64'h0, 64'hDEADBEEF, 37);
    run(IR, 7'd5, 64'h1F, 64'h01, 11);
    run(DR, 7'd8, 64'hA5, 64'h4A, 13);
    run(DR, 7'd0, 64'h1, 64'h0, 6);
    dv = 64'hF0E1D2C3B4A59687;
    run(DR, 7'd100, dv, dv << 1, 69);
    run(WT, 7'd0, 64'h0, 64'h0, 0);
    run(WT, 7'd4, '1, 64'h0, 4);
    n0 = rsp_cnt;
    issue(DR, 7'd32, 64'h0);
    repeat (52) @(posedge clk_in); #1;
    reset = 1;
    @(posedge clk_in); #1;
    chk("abort_tck", 64'(jtag_tck), 0);
    chk("abort_tms", 64'(jtag_tms), 1);
    chk("abort_ready", 64'(req_ready), 1);
    chk("abort_rsp_valid", 64'(rsp_valid), 0);
    chk("abort_rsp_data", rsp_data, 0);
    repeat (2) @(posedge clk_in); #1;
    reset = 0;
    repeat (200) @(posedge clk_in); #1;
    chk("abort_no_rsp", 64'(rsp_cnt - n0), 0);
    run(RST, 7'd0, 64'h0, 64'h0, 6);
    run(DR, 7'd32, 64'h0, 64'hDEADBEEF, 37);
    n0 = acc_cnt;
    @(posedge clk_in); #1;
    req_op = WT; req_len = 7'd3; req_data = 0; req_valid = 1;
    sb.push_back('{64'h0, 3});
    t = 0;
    while (acc_cnt == n0 && t < 100) begin @(posedge clk_in); #1; t++; end
    req_op = DR; req_len = 7'd32;
    sb.push_back('{64'hDEADBEEF, 37});
    low_cnt = 0;
    t = 0;
    while (acc_cnt == n0 + 1 && t < 500) begin @(posedge clk_in); #1; t++; end
    req_valid = 0;
    chk("b2b_accepts", 64'(acc_cnt - n0), 2);
    chk("b2b_gap", 64'(acc_cyc - rsp_cyc), 1);
    chk("b2b_busy_low", 64'(low_cnt), 1);
    wait_rsp();
    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
